// File: rtl/fetch_branch_unit.sv
// Tron CPU front end: PC, instruction register, PSR and condition logic.
// Feeds the controller FSM and applies its add/branch/jump commands.
module fetch_branch_unit #(
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             fetch_phase,
  input  logic [3:0]       flag_op,
  input  logic [7:0]       immediate,
  input  logic             pc_add,
  input  logic             pc_branch,
  input  logic             pc_jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [4:0]       flags_in,
  input  logic             flag_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus1,
  output logic [WIDTH-1:0] instruction,
  output logic [7:0]       instruction_op,
  output logic [4:0]       psr,
  output logic             cond_true
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ir;
  logic [4:0]       r_psr;
  logic [3:0]       r_cond;
  logic [7:0]       r_disp;

  logic [WIDTH-1:0] w_pc_plus1;
  logic [WIDTH-1:0] w_pc_branch;
  logic [WIDTH-1:0] w_instr;
  logic [3:0]       w_op;
  logic [3:0]       w_ext;
  logic [7:0]       w_dec;
  logic             w_cond;
  logic             w_n;
  logic             w_z;
  logic             w_f;
  logic             w_l;
  logic             w_c;

  assign w_pc_plus1  = r_pc + 1'b1;
  assign w_pc_branch = r_pc + {{(WIDTH-8){r_disp[7]}}, r_disp};
  assign w_instr     = fetch_phase ? mem_rdata : r_ir;
  assign w_op        = w_instr[15:12];
  assign w_ext       = w_instr[7:4];

  assign w_n = r_psr[4];
  assign w_z = r_psr[3];
  assign w_f = r_psr[2];
  assign w_l = r_psr[1];
  assign w_c = r_psr[0];

  // Opcode decode: some major opcodes carry a sub-opcode in bits [7:4]
  always_comb begin
    w_dec = {w_op, 4'b0000};
    if (w_op == 4'b0000 || w_op == 4'b0100) begin
      w_dec = {w_op, w_ext};
    end else if (w_op == 4'b1000) begin
      if (w_ext == 4'b0100) w_dec = 8'b1000_0100;
      else                  w_dec = {4'b1000, 3'b000, w_instr[4]};
    end
  end

  // Evaluate latched condition code against the registered flags
  always_comb begin
    w_cond = 1'b1;
    case (r_cond)
      4'b0000: w_cond = w_z;
      4'b0001: w_cond = !w_z;
      4'b0010: w_cond = w_c;
      4'b0011: w_cond = !w_c;
      4'b0100: w_cond = w_l;
      4'b0101: w_cond = !w_l;
      4'b0110: w_cond = w_n;
      4'b0111: w_cond = !w_n;
      4'b1000: w_cond = w_f;
      4'b1001: w_cond = !w_f;
      4'b1010: w_cond = !w_l && !w_z;
      4'b1011: w_cond = w_l || w_z;
      4'b1100: w_cond = !w_n && !w_z;
      4'b1101: w_cond = w_n || w_z;
      default: w_cond = 1'b1;
    endcase
  end

  // Capture instruction, condition and displacement only during fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir   <= '0;
      r_cond <= 4'b0000;
      r_disp <= 8'h00;
    end else if (fetch_phase) begin
      r_ir   <= mem_rdata;
      r_cond <= flag_op;
      r_disp <= immediate;
    end
  end

  // PC update; jump outranks branch, branch outranks sequential advance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (pc_jump) begin
      r_pc <= w_cond ? jump_target : w_pc_plus1;
    end else if (pc_branch) begin
      r_pc <= w_cond ? w_pc_branch : w_pc_plus1;
    end else if (pc_add) begin
      r_pc <= w_pc_plus1;
    end
  end

  // Flag register load from the ALU
  always_ff @(posedge clk) begin
    if (reset) begin
      r_psr <= 5'b00000;
    end else if (flag_write) begin
      r_psr <= flags_in;
    end
  end

  assign mem_addr       = r_pc;
  assign pc             = r_pc;
  assign pc_plus1       = w_pc_plus1;
  assign instruction    = w_instr;
  assign instruction_op = w_dec;
  assign psr            = r_psr;
  assign cond_true      = w_cond;

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Directed bench for fetch_branch_unit.
// Linear stimulus with hand-computed expectations.
module tb_fetch_branch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] mem_rdata;
  logic        fetch_phase;
  logic [3:0]  flag_op;
  logic [7:0]  immediate;
  logic        pc_add;
  logic        pc_branch;
  logic        pc_jump;
  logic [15:0] jump_target;
  logic [4:0]  flags_in;
  logic        flag_write;
  logic [15:0] mem_addr;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic [15:0] instruction;
  logic [7:0]  instruction_op;
  logic [4:0]  psr;
  logic        cond_true;

  int errors = 0;
  int checks = 0;

  fetch_branch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk),
    .reset(reset),
    .mem_rdata(mem_rdata),
    .fetch_phase(fetch_phase),
    .flag_op(flag_op),
    .immediate(immediate),
    .pc_add(pc_add),
    .pc_branch(pc_branch),
    .pc_jump(pc_jump),
    .jump_target(jump_target),
    .flags_in(flags_in),
    .flag_write(flag_write),
    .mem_addr(mem_addr),
    .pc(pc),
    .pc_plus1(pc_plus1),
    .instruction(instruction),
    .instruction_op(instruction_op),
    .psr(psr),
    .cond_true(cond_true)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load an always-true condition, then jump to addr
  task automatic goto(input logic [15:0] addr);
    fetch_phase = 1'b1;
    flag_op     = 4'b1110;
    tick();
    fetch_phase = 1'b0;
    pc_jump     = 1'b1;
    jump_target = addr;
    tick();
    pc_jump     = 1'b0;
  endtask

  logic [15:0] sweep_in  [5];
  logic [7:0]  sweep_exp [5];

  initial begin
    sweep_in[0] = 16'h8314; sweep_exp[0] = 8'h81;
    sweep_in[1] = 16'h8340; sweep_exp[1] = 8'h84;
    sweep_in[2] = 16'h5307; sweep_exp[2] = 8'h50;
    sweep_in[3] = 16'hF3AB; sweep_exp[3] = 8'hF0;
    sweep_in[4] = 16'h4304; sweep_exp[4] = 8'h40;

    reset       = 1'b1;
    mem_rdata   = 16'h0000;
    fetch_phase = 1'b0;
    flag_op     = 4'b0000;
    immediate   = 8'h00;
    pc_add      = 1'b0;
    pc_branch   = 1'b0;
    pc_jump     = 1'b0;
    jump_target = 16'h0000;
    flags_in    = 5'b00000;
    flag_write  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    chk("rst_pc", pc, 16'h0000);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_op", instruction_op, 8'h00);
    chk("rst_psr", psr, 5'b00000);
    chk("rst_cond", cond_true, 1'b0);

    // ADD r2,r5 fetch with simultaneous pc_add
    fetch_phase = 1'b1;
    mem_rdata   = 16'h0215;
    flag_op     = 4'b1110;
    pc_add      = 1'b1;
    #1;
    chk("add_instr", instruction, 16'h0215);
    chk("add_op", instruction_op, 8'h01);
    tick();
    fetch_phase = 1'b0;
    pc_add      = 1'b0;
    mem_rdata   = 16'hFFFF;
    #1;
    chk("add_pc", pc, 16'h0001);
    chk("add_pc1", pc_plus1, 16'h0002);
    chk("ir_hold", instruction, 16'h0215);
    chk("ir_hold_op", instruction_op, 8'h01);

    // BEQ taken
    goto(16'h0010);
    chk("goto10", pc, 16'h0010);
    fetch_phase = 1'b1;
    mem_rdata   = 16'hC0FE;
    flag_op     = 4'b0000;
    immediate   = 8'hFE;
    flag_write  = 1'b1;
    flags_in    = 5'b01000;
    tick();
    fetch_phase = 1'b0;
    flag_write  = 1'b0;
    chk("beq_psr", psr, 5'b01000);
    chk("beq_cond_t", cond_true, 1'b1);
    pc_branch = 1'b1;
    tick();
    pc_branch = 1'b0;
    chk("beq_taken", pc, 16'h000E);

    // BEQ not taken
    goto(16'h0010);
    fetch_phase = 1'b1;
    mem_rdata   = 16'hC0FE;
    flag_op     = 4'b0000;
    immediate   = 8'hFE;
    flag_write  = 1'b1;
    flags_in    = 5'b00000;
    tick();
    fetch_phase = 1'b0;
    flag_write  = 1'b0;
    chk("beq_cond_f", cond_true, 1'b0);
    pc_branch = 1'b1;
    tick();
    pc_branch = 1'b0;
    chk("beq_nt", pc, 16'h0011);

    // JCOND always / JCOND NE with Z set
    goto(16'h1234);
    chk("jc_taken", pc, 16'h1234);
    fetch_phase = 1'b1;
    flag_op     = 4'b0001;
    flag_write  = 1'b1;
    flags_in    = 5'b01000;
    tick();
    fetch_phase = 1'b0;
    flag_write  = 1'b0;
    chk("jne_cond", cond_true, 1'b0);
    pc_jump     = 1'b1;
    jump_target = 16'h5555;
    tick();
    pc_jump = 1'b0;
    chk("jne_nt", pc, 16'h1235);

    // JAL
    goto(16'h0020);
    fetch_phase = 1'b1;
    mem_rdata   = 16'h4E8A;
    flag_op     = 4'b1111;
    #1;
    chk("jal_op", instruction_op, 8'h48);
    tick();
    fetch_phase = 1'b0;
    pc_add      = 1'b1;
    tick();
    pc_add = 1'b0;
    chk("jal_pc", pc, 16'h0021);
    chk("jal_link", pc_plus1, 16'h0022);
    pc_jump     = 1'b1;
    jump_target = 16'h0300;
    tick();
    pc_jump = 1'b0;
    chk("jal_jump", pc, 16'h0300);

    // Decode sweep on the live fetch path
    fetch_phase = 1'b1;
    flag_op     = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      mem_rdata = sweep_in[i];
      #1;
      chk($sformatf("dec_%0d", i), instruction_op, sweep_exp[i]);
    end
    mem_rdata = 16'h8314;
    tick();
    fetch_phase = 1'b0;
    mem_rdata   = 16'h0000;
    #1;
    chk("dec_ir", instruction_op, 8'h81);

    // Fetch with a jump: jump uses old cond (1111), new cond (0001) later
    fetch_phase = 1'b1;
    flag_op     = 4'b0001;
    pc_jump     = 1'b1;
    jump_target = 16'h0700;
    tick();
    fetch_phase = 1'b0;
    pc_jump     = 1'b0;
    chk("fj_pc", pc, 16'h0700);
    chk("fj_newcond", cond_true, 1'b0);

    // PC wrap
    goto(16'hFFFF);
    chk("wrap_pre", pc, 16'hFFFF);
    chk("wrap_pc1", pc_plus1, 16'h0000);
    pc_add = 1'b1;
    tick();
    pc_add = 1'b0;
    chk("wrap", pc, 16'h0000);

    // flag_write and branch in the same cycle: old psr decides
    fetch_phase = 1'b1;
    flag_op     = 4'b0000;
    immediate   = 8'h05;
    flag_write  = 1'b1;
    flags_in    = 5'b00000;
    tick();
    fetch_phase = 1'b0;
    pc_branch   = 1'b1;
    flags_in    = 5'b01000;
    tick();
    pc_branch  = 1'b0;
    flag_write = 1'b0;
    chk("fw_nt", pc, 16'h0001);
    chk("fw_psr", psr, 5'b01000);
    chk("fw_cond", cond_true, 1'b1);

    // Reset overrides a taken jump
    pc_jump     = 1'b1;
    jump_target = 16'h4444;
    reset       = 1'b1;
    tick();
    reset   = 1'b0;
    pc_jump = 1'b0;
    #1;
    chk("rj_pc", pc, 16'h0000);
    chk("rj_psr", psr, 5'b00000);
    chk("rj_cond", cond_true, 1'b0);
    chk("rj_instr", instruction, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
